mem_arbiter: RTL
================

# mem_arbiter

Arbitrates the datapath's instruction-fetch and data-memory requests onto the single shared RAM port. It sits between the datapath/cache requesters and the RAM. It serialises accesses with a registered-grant FSM: data requests have priority, a streak limit prevents instruction starvation, and failed RAM accesses are retried up to a bound before a fault is raised.

## Interface
Parameters:
- MAX_DSTREAK, 4: consecutive data grants allowed while an instruction request waits; range 1–15.
- MAX_RETRY, 3: number of ERROR responses tolerated per access before fault is asserted; range 1–15.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction word address.
- iwait  out  1  high while an instruction request is not yet satisfied.
- iload  out  32  instruction read data.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- dwait  out  1  high while a data request is not yet satisfied.
- dload  out  32  data read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status, type ramstate_t.
- fault  out  1  sticky retry-exhausted flag.

## Operation
- FSM states: IDLE, GRANT_I, GRANT_D. Reset state is IDLE.
- Data request (dreq) = dREN | dWEN. If both dREN and dWEN are high, the access is a write: ramWEN=1, ramREN=0.
- Transitions out of IDLE:
  - dreq, and not (streak==MAX_DSTREAK & iREN) -> GRANT_D.
  - else iREN -> GRANT_I.
  - else stay in IDLE.
- In GRANT_D: ramaddr=daddr, ramstore=dstore, enables follow dREN/dWEN.
- In GRANT_I: ramREN=1, ramaddr=iaddr.
- In IDLE: all ram outputs are 0.
- In GRANT_x:
  - ramstate==ACCESS: the access completes. Go to IDLE and clear retry.
  - ramstate==ERROR: increment retry. If retry reaches MAX_RETRY, set fault (sticky); stay granted and keep retrying. Otherwise stay granted.
  - ramstate FREE or BUSY: hold.
  - Owning request withdrawn: go to IDLE next cycle and clear retry.
- iwait = ~(state==GRANT_I & ramstate==ACCESS); dwait = ~(state==GRANT_D & ramstate==ACCESS). Both are combinational.
- iload = dload = ramload, passed through.
- Streak counter (4 bits):
  - On a data ACCESS with iREN high: increment, saturating at MAX_DSTREAK.
  - On a data ACCESS with iREN low: clear.
  - On an instruction ACCESS: clear.
- Reset mid-access: return to IDLE, clear streak and retry, clear fault. RAM enables drop asynchronously.

## Timing
- Reset values: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, fault=0.
- Grant is registered. A request first seen in cycle N drives the RAM from cycle N+1.
- Minimum latency is 2 cycles: ACCESS in N+1 drops wait in N+1, and a new grant is possible in N+3.
- There is one mandatory IDLE bubble between accesses.
- ERROR costs one cycle per retry. fault rises the cycle after the MAX_RETRY-th ERROR.
- iaddr, daddr and dstore are sampled combinationally every granted cycle. Requesters must hold them stable until wait drops.

## Structure
- cpu_types_pkg holds:
  - ramstate_t: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
  - word_t (32 bits).
  - The arbiter state enum arb_state_t.
- Single module: one always_ff for state and counters, one always_comb for next-state and outputs. No sub-module is warranted.

## Test plan
- Reset, then iREN=1 with iaddr=0x40 and the RAM answering ACCESS after 2 BUSY cycles -> ramREN=1 and ramaddr=0x40 from cycle 1; iwait=0 only in cycle 3; IDLE in cycle 4.
- iREN and dREN asserted together with daddr=0x100 -> GRANT_D first; the instruction is granted after the data ACCESS plus one bubble.
- Continuous dWEN plus iREN with MAX_DSTREAK=4 -> exactly 4 data writes, then 1 instruction grant, then streak=0.
- dREN=dWEN=1 with dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
- RAM returns ERROR 3 times with MAX_RETRY=3 -> fault=1 the following cycle and held; a later ACCESS completes normally; fault cleared only by nRST.
- dREN is dropped during BUSY -> IDLE next cycle and ramREN=0; nRST asserted mid-GRANT_I -> all outputs return to their reset values immediately.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the datapath / memory subsystem:
//   word_t       32-bit machine word
//   ramstate_t   status reported by the RAM each cycle
//   arb_state_t  state encoding of the memory arbiter FSM
// Also holds a small saturating-increment helper used by the arbiter's
// streak and retry counters.
// ---------------------------------------------------------------------------
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  // 4-bit increment that stops at lim (and never wraps past it).
  function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
    logic [3:0] r;
    if (v >= lim) begin
      r = lim;
    end else begin
      r = v + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the requester-side (instruction fetch / data memory) and RAM-side
// signals of the memory arbiter.
//   slave  : the arbiter's view (takes requests and RAM status, drives waits,
//            load data and the RAM command)
//   master : the environment's view (requesters plus RAM)
// Signal names match the existing datapath naming (iREN, dwait, ramaddr ...).
// ---------------------------------------------------------------------------
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  // instruction requester
  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  // data requester
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  // RAM port
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Serialises instruction-fetch and data-memory requests onto one RAM port.
// Grants are registered (IDLE -> GRANT_I / GRANT_D); data requests win, but
// after MAX_DSTREAK consecutive data accesses with an instruction waiting the
// instruction is served. RAM ERROR responses are retried in place; once
// MAX_RETRY errors hit one access, the sticky fault flag is raised.
//
// Ports:
//   CLK    clock
//   nRST   asynchronous active-low reset
//   bus    mem_arbiter_if.slave (requests, waits, load data, RAM command)
//   fault  sticky retry-exhausted flag (cleared only by nRST)
// ---------------------------------------------------------------------------
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = 4,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic                CLK,
  input  logic                nRST,
  mem_arbiter_if.slave        bus,
  output logic                fault
);

  localparam logic [3:0] STREAK_LIM = 4'(MAX_DSTREAK);
  localparam logic [3:0] RETRY_LIM  = 4'(MAX_RETRY);

  arb_state_t state_q, state_d;
  logic [3:0] streak_q, streak_d;
  logic [3:0] retry_q, retry_d;
  logic       fault_q, fault_d;

  logic       dreq_s;
  logic [3:0] retry_inc_s;
  logic       ram_ren_s;
  logic       ram_wen_s;
  word_t      ram_addr_s;
  word_t      ram_store_s;

  assign dreq_s      = bus.dREN | bus.dWEN;
  assign retry_inc_s = sat_inc4(retry_q, RETRY_LIM);

  // Next-state, counter updates and RAM command for the current grant.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    retry_d     = retry_q;
    fault_d     = fault_q;
    ram_ren_s   = 1'b0;
    ram_wen_s   = 1'b0;
    ram_addr_s  = 32'h0000_0000;
    ram_store_s = 32'h0000_0000;

    case (state_q)
      IDLE: begin
        // Data wins unless its streak is used up while a fetch waits.
        if (dreq_s && !((streak_q == STREAK_LIM) && bus.iREN)) begin
          state_d = GRANT_D;
        end else if (bus.iREN) begin
          state_d = GRANT_I;
        end else begin
          state_d = IDLE;
        end
      end

      GRANT_I: begin
        ram_ren_s  = 1'b1;
        ram_addr_s = bus.iaddr;
        if (!bus.iREN) begin
          state_d = IDLE;
          retry_d = 4'd0;
        end else if (bus.ramstate == ACCESS) begin
          state_d  = IDLE;
          retry_d  = 4'd0;
          streak_d = 4'd0;
        end else if (bus.ramstate == ERROR) begin
          retry_d = retry_inc_s;
          if (retry_inc_s >= RETRY_LIM) begin
            fault_d = 1'b1;
          end else begin
            fault_d = fault_q;
          end
        end else begin
          state_d = GRANT_I;
        end
      end

      GRANT_D: begin
        // A simultaneous read+write request is treated as a write.
        ram_wen_s   = bus.dWEN;
        ram_ren_s   = bus.dREN & ~bus.dWEN;
        ram_addr_s  = bus.daddr;
        ram_store_s = bus.dstore;
        if (!dreq_s) begin
          state_d = IDLE;
          retry_d = 4'd0;
        end else if (bus.ramstate == ACCESS) begin
          state_d = IDLE;
          retry_d = 4'd0;
          // Streak only grows while an instruction is actually being held off.
          if (bus.iREN) begin
            streak_d = sat_inc4(streak_q, STREAK_LIM);
          end else begin
            streak_d = 4'd0;
          end
        end else if (bus.ramstate == ERROR) begin
          retry_d = retry_inc_s;
          if (retry_inc_s >= RETRY_LIM) begin
            fault_d = 1'b1;
          end else begin
            fault_d = fault_q;
          end
        end else begin
          state_d = GRANT_D;
        end
      end

      default: begin
        state_d  = IDLE;
        retry_d  = 4'd0;
        streak_d = 4'd0;
      end
    endcase
  end

  // State and counter registers; reset drops the grant (and RAM enables) at once.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      streak_q <= 4'd0;
      retry_q  <= 4'd0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      retry_q  <= retry_d;
      fault_q  <= fault_d;
    end
  end

  assign bus.ramREN   = ram_ren_s;
  assign bus.ramWEN   = ram_wen_s;
  assign bus.ramaddr  = ram_addr_s;
  assign bus.ramstore = ram_store_s;

  // Waits drop in the very cycle the RAM reports completion of that grant.
  assign bus.iwait = ~((state_q == GRANT_I) && (bus.ramstate == ACCESS));
  assign bus.dwait = ~((state_q == GRANT_D) && (bus.ramstate == ACCESS));

  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;

  assign fault = fault_q;

endmodule
